// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator request scheduler.
// Contents:
//   FloorW           - default floor index width
//   DefaultNumFloors - default number of served floors
//   elev_state_e     - scheduler state (idle, sweeping up, sweeping down, door dwell)
package elevator_pkg;

  localparam int unsigned FloorW           = 4;
  localparam int unsigned DefaultNumFloors = 16;

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown,
    StDwell
  } elev_state_e;

endpackage

// File: rtl/elevator_floor_finder.sv
// Combinational nearest-request search around the current floor.
// Ports:
//   pending   - outstanding request bitmap, one bit per floor
//   cur_floor - current car floor
//   up_hit    - nearest pending floor strictly above cur_floor (valid when up_vld)
//   dn_hit    - nearest pending floor strictly below cur_floor (valid when dn_vld)
module elevator_floor_finder
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = DefaultNumFloors,
  parameter int unsigned FLOOR_W    = FloorW
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [FLOOR_W-1:0]    up_hit,
  output logic                  up_vld,
  output logic [FLOOR_W-1:0]    dn_hit,
  output logic                  dn_vld
);

  always_comb begin
    up_hit = '0;
    up_vld = 1'b0;
    dn_hit = '0;
    dn_vld = 1'b0;
    // Scan top-down so the last match is the lowest floor above the car.
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(cur_floor))) begin
        up_hit = FLOOR_W'(i);
        up_vld = 1'b1;
      end
    end
    // Scan bottom-up so the last match is the highest floor below the car.
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending[i] && (i < int'(cur_floor))) begin
        dn_hit = FLOOR_W'(i);
        dn_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN elevator scheduler: latches floor calls into a pending bitmap and picks the next
// target floor for the car controller, clearing requests on arrival and dwelling with the
// door open before choosing the next target.
// Optional feature: define ELEV_SCHED_DWELL_EN to make the dwell last DWELL_CYCLES clocks;
// otherwise the dwell lasts exactly one clock and no counter is built.
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   call_btn  - per-floor call buttons (level or pulse)
//   cur_floor - current floor reported by the car controller
//   floor_req - registered target floor to the car controller
//   req_valid - high while a target is being served or dwelled on
//   dir_up    - sweep direction, 1 = up
//   pending   - registered outstanding requests
//   door_open - high during the dwell
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS   = DefaultNumFloors,
  parameter int unsigned FLOOR_W      = FloorW,
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [FLOOR_W-1:0]    floor_req,
  output logic                  req_valid,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open
);

  if (NUM_FLOORS < 2 || NUM_FLOORS > (1 << FLOOR_W) || DWELL_CYCLES < 1 ||
      DWELL_CYCLES > 255) begin : gen_param_err
    $error("elevator_request_scheduler: parameter out of range");
  end

  elev_state_e           state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, clr;
  logic [FLOOR_W-1:0]    floor_req_q, floor_req_d;
  logic                  req_valid_q, req_valid_d;
  logic                  dir_up_q, dir_up_d;
  logic                  door_open_q, door_open_d;

  logic [FLOOR_W-1:0]    up_hit, dn_hit, up_dist, dn_dist;
  logic                  up_vld, dn_vld, here, arrived, dwell_done;
  logic [NUM_FLOORS-1:0] cur_bit;

  // One-hot of a floor; all-zero for out-of-range floors so they never match or clear.
  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (int'(f) == i) v[i] = 1'b1;
    end
    return v;
  endfunction

  elevator_floor_finder #(
    .NUM_FLOORS(NUM_FLOORS),
    .FLOOR_W   (FLOOR_W)
  ) u_finder (
    .pending  (pending_q),
    .cur_floor(cur_floor),
    .up_hit   (up_hit),
    .up_vld   (up_vld),
    .dn_hit   (dn_hit),
    .dn_vld   (dn_vld)
  );

  assign cur_bit = floor_bit(cur_floor);
  assign here    = |(pending_q & cur_bit);
  assign arrived = (cur_floor == floor_req_q) && (|cur_bit);
  assign up_dist = up_hit - cur_floor;
  assign dn_dist = cur_floor - dn_hit;

  always_comb begin
    state_d     = state_q;
    floor_req_d = floor_req_q;
    req_valid_d = req_valid_q;
    dir_up_d    = dir_up_q;
    door_open_d = 1'b0;
    clr         = '0;
    unique case (state_q)
      StIdle: begin
        req_valid_d = 1'b0;
        floor_req_d = cur_floor;
        if (here) begin
          // Same-floor call: open the door without issuing a movement request.
          clr         = cur_bit;
          state_d     = StDwell;
          door_open_d = 1'b1;
        end else if (up_vld && (!dn_vld || (up_dist <= dn_dist))) begin
          floor_req_d = up_hit;
          dir_up_d    = 1'b1;
          req_valid_d = 1'b1;
          state_d     = StUp;
        end else if (dn_vld) begin
          floor_req_d = dn_hit;
          dir_up_d    = 1'b0;
          req_valid_d = 1'b1;
          state_d     = StDown;
        end
      end
      StUp: begin
        if (arrived) begin
          clr         = cur_bit;
          state_d     = StDwell;
          door_open_d = 1'b1;
        end else if (up_vld && (up_hit < floor_req_q)) begin
          floor_req_d = up_hit;
        end
      end
      StDown: begin
        if (arrived) begin
          clr         = cur_bit;
          state_d     = StDwell;
          door_open_d = 1'b1;
        end else if (dn_vld && (dn_hit > floor_req_q)) begin
          floor_req_d = dn_hit;
        end
      end
      StDwell: begin
        // Calls at the dwelled floor are absorbed for the whole dwell.
        clr = floor_bit(floor_req_q);
        if (!dwell_done) begin
          door_open_d = 1'b1;
        end else if (up_vld && (dir_up_q || !dn_vld)) begin
          floor_req_d = up_hit;
          dir_up_d    = 1'b1;
          req_valid_d = 1'b1;
          state_d     = StUp;
        end else if (dn_vld) begin
          floor_req_d = dn_hit;
          dir_up_d    = 1'b0;
          req_valid_d = 1'b1;
          state_d     = StDown;
        end else begin
          req_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    pending_d = (pending_q | call_btn) & ~clr;
  end

`ifdef ELEV_SCHED_DWELL_EN
  logic [7:0] dwell_cnt_q, dwell_cnt_d;

  // Loaded with DWELL_CYCLES-1 on entry; the dwell ends on the edge after it reaches 0.
  always_comb begin
    dwell_cnt_d = dwell_cnt_q;
    if ((state_q != StDwell) && (state_d == StDwell)) begin
      dwell_cnt_d = 8'(DWELL_CYCLES - 1);
    end else if ((state_q == StDwell) && (dwell_cnt_q != 8'd0)) begin
      dwell_cnt_d = dwell_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dwell_cnt_q <= 8'd0;
    else      dwell_cnt_q <= dwell_cnt_d;
  end

  assign dwell_done = (dwell_cnt_q == 8'd0);
`else
  assign dwell_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      floor_req_q <= '0;
      req_valid_q <= 1'b0;
      dir_up_q    <= 1'b1;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      floor_req_q <= floor_req_d;
      req_valid_q <= req_valid_d;
      dir_up_q    <= dir_up_d;
      door_open_q <= door_open_d;
    end
  end

  assign floor_req = floor_req_q;
  assign req_valid = req_valid_q;
  assign dir_up    = dir_up_q;
  assign pending   = pending_q;
  assign door_open = door_open_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
module tb_elevator_request_scheduler;

  localparam int NF = 16;
  localparam int FW = 4;
`ifdef ELEV_SCHED_DWELL_EN
  localparam int DL = 4;
`else
  localparam int DL = 1;
`endif
  localparam int Budget = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] call_btn;
  logic [FW-1:0] cur_floor;
  logic [FW-1:0] floor_req;
  logic          req_valid;
  logic          dir_up;
  logic [NF-1:0] pending;
  logic          door_open;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];       // expected sequence of served floors
  bit auto_car;
  int move_period;
  int move_cnt;
  bit model_dir;      // expected sweep direction after the current batch completes

  always #5 clk = ~clk;

  elevator_request_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .call_btn (call_btn),
    .cur_floor(cur_floor),
    .floor_req(floor_req),
    .req_valid(req_valid),
    .dir_up   (dir_up),
    .pending  (pending),
    .door_open(door_open)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One clock; afterwards the car model advances toward floor_req if it is moving.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_car && req_valid && !door_open && (cur_floor != floor_req)) begin
      move_cnt++;
      if (move_cnt >= move_period) begin
        move_cnt = 0;
        if (floor_req > cur_floor) cur_floor = cur_floor + 4'd1;
        else                       cur_floor = cur_floor - 4'd1;
      end
    end
  endtask

  task automatic press(input logic [NF-1:0] btns);
    call_btn = btns;
    step();
    call_btn = '0;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (!((exp_q.size() == 0) && !req_valid && !door_open && (pending == '0)) &&
           (cyc < Budget)) begin
      step();
      cyc++;
    end
    check({name, "_idle_in_budget"}, int'(cyc < Budget), 1);
  endtask

  // SCAN service order for a batch of calls made while idle at floor f.
  task automatic model_batch(input int f, input logic [NF-1:0] s_in);
    logic [NF-1:0] s;
    int up_n, dn_n;
    bit any_up, any_dn, go_up;
    s    = s_in;
    up_n = -1;
    dn_n = -1;
    if (s[f]) exp_q.push_back(f);
    s[f] = 1'b0;
    for (int i = NF - 1; i > f; i--) if (s[i]) up_n = i;
    for (int i = 0; i < f; i++) if (s[i]) dn_n = i;
    any_up = (up_n >= 0);
    any_dn = (dn_n >= 0);
    if (s_in[f]) go_up = model_dir ? (any_up || !any_dn) : (any_up && !any_dn);
    else         go_up = any_up && (!any_dn || ((up_n - f) <= (f - dn_n)));
    if (any_up || any_dn) begin
      if (go_up) begin
        for (int i = f + 1; i < NF; i++) if (s[i]) exp_q.push_back(i);
        for (int i = f - 1; i >= 0; i--) if (s[i]) exp_q.push_back(i);
        model_dir = !any_dn;
      end else begin
        for (int i = f - 1; i >= 0; i--) if (s[i]) exp_q.push_back(i);
        for (int i = f + 1; i < NF; i++) if (s[i]) exp_q.push_back(i);
        model_dir = any_up;
      end
    end
  endtask

  // Monitor: every door opening is a service event checked against the scoreboard.
  initial begin : monitor
    int  exp_floor;
    int  dwell_len;
    bit  prev_door;
    exp_floor = -1;
    dwell_len = 0;
    prev_door = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_door = 1'b0;
        dwell_len = 0;
      end else begin
        if (door_open && !prev_door) begin
          check("svc_expected", int'(exp_q.size() != 0), 1);
          exp_floor = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
          dwell_len = 0;
        end
        if (door_open) begin
          dwell_len++;
          check("svc_floor", int'(floor_req), exp_floor);
          check("svc_bit_clear", int'(pending[floor_req]), 0);
        end
        if (!door_open && prev_door) check("dwell_len", dwell_len, DL);
        prev_door = door_open;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [NF-1:0] s;
    rst         = 1'b0;
    call_btn    = '0;
    cur_floor   = '0;
    auto_car    = 1'b0;
    move_period = 2;
    move_cnt    = 0;
    model_dir   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pending", int'(pending), 0);
    check("rst_floor_req", int'(floor_req), 0);
    check("rst_req_valid", int'(req_valid), 0);
    check("rst_dir_up", int'(dir_up), 1);
    check("rst_door", int'(door_open), 0);
    rst = 1'b1;
    step();

    // Single call from floor 0 to floor 5.
    exp_q.push_back(5);
    press(16'h0020);
    check("single_latch", int'(pending), 'h20);
    check("single_no_req_yet", int'(req_valid), 0);
    step();
    check("single_floor_req", int'(floor_req), 5);
    check("single_req_valid", int'(req_valid), 1);
    check("single_dir", int'(dir_up), 1);
    cur_floor = 4'd5;
    step();
    check("single_door", int'(door_open), 1);
    check("single_cleared", int'(pending), 0);
    wait_idle("single");
    check("single_idle_floor", int'(floor_req), 5);
    check("single_idle_valid", int'(req_valid), 0);

    // Pickup on the way: heading to 9 from 2, floor 4 is pressed.
    cur_floor = 4'd2;
    step();
    exp_q.push_back(4);
    exp_q.push_back(9);
    press(16'h0200);
    step();
    check("pickup_first_target", int'(floor_req), 9);
    press(16'h0010);
    check("pickup_bit_set", int'(pending), 'h210);
    check("pickup_not_yet", int'(floor_req), 9);
    step();
    check("pickup_retarget", int'(floor_req), 4);
    auto_car = 1'b1;
    wait_idle("pickup");
    check("pickup_dir", int'(dir_up), 1);

    // Reversal: {3,12} from 8 goes up first (4 vs 5), then down.
    cur_floor = 4'd8;
    step();
    model_batch(8, 16'h1008);
    press(16'h1008);
    step();
    check("rev_first_target", int'(floor_req), 12);
    check("rev_first_dir", int'(dir_up), 1);
    wait_idle("rev");
    check("rev_final_dir", int'(dir_up), int'(model_dir));
    check("rev_final_floor", int'(floor_req), 3);

    // Distance tie at floor 6 between 4 and 8 goes up.
    cur_floor = 4'd6;
    step();
    model_batch(6, 16'h0110);
    press(16'h0110);
    step();
    check("tie_target", int'(floor_req), 8);
    check("tie_dir", int'(dir_up), 1);
    wait_idle("tie");
    check("tie_final_dir", int'(dir_up), int'(model_dir));

    // Same-floor call while idle, then a press at that floor during the dwell.
    cur_floor = 4'd6;
    step();
    model_batch(6, 16'h0040);
    press(16'h0040);
    check("same_latch", int'(pending), 'h40);
    step();
    check("same_door", int'(door_open), 1);
    check("same_no_req", int'(req_valid), 0);
    check("same_cleared", int'(pending), 0);
    press(16'h0040);
    check("same_absorb", int'(pending[6]), 0);
    step();
    check("same_absorb_after", int'(pending), 0);
    wait_idle("same");

    // Randomized batches checked against the SCAN model.
    for (int b = 0; b < 14; b++) begin
      move_period = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        cur_floor = 4'($urandom_range(0, NF - 1));
        step();
      end
      s = 16'($urandom) & 16'($urandom);
      if (s == '0) s[$urandom_range(0, NF - 1)] = 1'b1;
      model_batch(int'(cur_floor), s);
      press(s);
      check("batch_latch", int'(pending), int'(s));
      wait_idle("batch");
      check("batch_dir", int'(dir_up), int'(model_dir));
    end
    check("queue_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of an upward sweep with pending = 0x0028.
    auto_car  = 1'b0;
    cur_floor = 4'd0;
    step();
    press(16'h0028);
    step();
    check("mid_pending", int'(pending), 'h28);
    check("mid_target", int'(floor_req), 3);
    check("mid_valid", int'(req_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_pending", int'(pending), 0);
    check("async_floor_req", int'(floor_req), 0);
    check("async_req_valid", int'(req_valid), 0);
    check("async_dir_up", int'(dir_up), 1);
    check("async_door", int'(door_open), 0);
    repeat (2) step();
    rst = 1'b1;
    step();
    check("post_rst_pending", int'(pending), 0);
    check("post_rst_valid", int'(req_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
